// File: rtl/order_arbiter.sv
// Round-robin scheduler sharing the matching engine's single order-entry port.
// Issues one registered order at a time, then idles GAP cycles so the book settles.
module order_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int PRICE_W = 8,
    parameter int GAP     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC-1:0]         side,
    input  logic [NUM_SRC*PRICE_W-1:0] price,
    input  logic                       halt,
    output logic [NUM_SRC-1:0]         grant,
    output logic                       out_valid,
    output logic                       out_side,
    output logic [PRICE_W-1:0]         out_price,
    output logic [SRC_W-1:0]           out_src,
    output logic                       busy,
    output logic [7:0]                 order_count,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_GAP    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t               state, state_d;
    logic [3:0]           gap_cnt, gap_cnt_d;
    logic [SRC_W-1:0]     last_grant, last_grant_d;
    logic [NUM_SRC-1:0]   grant_d;
    logic                 valid_d, side_d, busy_d;
    logic [PRICE_W-1:0]   price_d;
    logic [SRC_W-1:0]     src_d;
    logic [7:0]           count_d;

    logic                 found;
    logic [SRC_W-1:0]     sel, cand;

    // Search starts one past the last winner so a continuous requester waits at most NUM_SRC slots.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state;
        gap_cnt_d    = gap_cnt;
        last_grant_d = last_grant;
        grant_d      = '0;
        valid_d      = 1'b0;
        side_d       = out_side;
        price_d      = out_price;
        src_d        = out_src;
        count_d      = order_count;
        case (state)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (found) begin
                    grant_d      = NUM_SRC'(1) << sel;
                    valid_d      = 1'b1;
                    side_d       = side[sel];
                    price_d      = price[int'(sel)*PRICE_W +: PRICE_W];
                    src_d        = sel;
                    last_grant_d = sel;
                    count_d      = order_count + 8'd1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_INIT;
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_d = S_IDLE;
                else                 gap_cnt_d = gap_cnt - 4'd1;
            end
            S_HALTED: begin
                if (!halt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ISSUE) || (state_d == S_GAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            gap_cnt     <= 4'd0;
            last_grant  <= SRC_W'(NUM_SRC - 1);
            grant       <= '0;
            out_valid   <= 1'b0;
            out_side    <= 1'b0;
            out_price   <= '0;
            out_src     <= '0;
            busy        <= 1'b0;
            order_count <= 8'd0;
        end else begin
            state       <= state_d;
            gap_cnt     <= gap_cnt_d;
            last_grant  <= last_grant_d;
            grant       <= grant_d;
            out_valid   <= valid_d;
            out_side    <= side_d;
            out_price   <= price_d;
            out_src     <= src_d;
            busy        <= busy_d;
            order_count <= count_d;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_order_arbiter.sv
// Scoreboard bench for order_arbiter: default GAP=2 instance plus a GAP=0 instance.
// Handshake: an order is transferred on every cycle out_valid is high; grant pulses alongside it.
module tb_order_arbiter;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int W  = 19;  // {src[1:0], side, price[7:0], count[7:0]}

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0, req0 = '0;
    logic [N-1:0]  side = '0, side0 = '0;
    logic [N*PW-1:0] price = '0, price0 = '0;
    logic          halt = 1'b0;

    logic [N-1:0]  grant, grant0;
    logic          out_valid, out_valid0, out_side, out_side0, busy, busy0;
    logic [PW-1:0] out_price, out_price0;
    logic [1:0]    out_src, out_src0, state_dbg, state_dbg0;
    logic [7:0]    order_count, order_count0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp0_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int space_chk = 0;
    int space_chk0 = 0;
    int exp_count = 0;

    order_arbiter #(.NUM_SRC(N), .SRC_W(2), .PRICE_W(PW), .GAP(2)) dut (
        .clk(clk), .reset(reset), .req(req), .side(side), .price(price), .halt(halt),
        .grant(grant), .out_valid(out_valid), .out_side(out_side), .out_price(out_price),
        .out_src(out_src), .busy(busy), .order_count(order_count), .state_dbg(state_dbg)
    );

    order_arbiter #(.NUM_SRC(N), .SRC_W(2), .PRICE_W(PW), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .side(side0), .price(price0), .halt(1'b0),
        .grant(grant0), .out_valid(out_valid0), .out_side(out_side0), .out_price(out_price0),
        .out_src(out_src0), .busy(busy0), .order_count(order_count0), .state_dbg(state_dbg0)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk(input int src, input logic sd, input logic [7:0] pr, input int cnt);
        return {2'(src), sd, pr, 8'(cnt)};
    endfunction

    // ---------------- monitors ----------------
    logic [W-1:0] e_m, e_m0;
    int prev_m = 0, prev_m0 = 0;
    bit have_m = 0, have_m0 = 0;

    always @(negedge clk) begin
        if (space_chk == 0) have_m = 0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_order", {out_src, out_side, out_price, order_count}, 0);
            end else begin
                e_m = exp_q.pop_front();
                check("order", {out_src, out_side, out_price, order_count}, e_m);
                check("grant_onehot", grant, N'(1) << e_m[18:17]);
            end
            if (space_chk != 0 && have_m) check("spacing", cyc - prev_m, space_chk);
            prev_m = cyc;
            have_m = 1;
        end else begin
            check("grant_wo_valid", grant, 0);
        end
    end

    always @(negedge clk) begin
        if (space_chk0 == 0) have_m0 = 0;
        if (out_valid0) begin
            if (exp0_q.size() == 0) begin
                check("gap0_unexpected", {out_src0, out_side0, out_price0, order_count0}, 0);
            end else begin
                e_m0 = exp0_q.pop_front();
                check("gap0_order", {out_src0, out_side0, out_price0, order_count0}, e_m0);
                check("gap0_grant", grant0, N'(1) << e_m0[18:17]);
            end
            if (space_chk0 != 0 && have_m0) check("gap0_spacing", cyc - prev_m0, space_chk0);
            prev_m0 = cyc;
            have_m0 = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic push(input int src, input logic sd, input logic [7:0] pr);
        exp_count = exp_count + 1;
        exp_q.push_back(mk(src, sd, pr, exp_count));
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (grant != 0) return;
        end
        check("grant_timeout", 0, 1);
    endtask

    task automatic wait_empty(input bit which, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if ((which ? exp0_q.size() : exp_q.size()) == 0) return;
        end
        check(which ? "gap0_drain_timeout" : "drain_timeout", 0, 1);
        if (which) exp0_q.delete();
        else       exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int n, bcnt;
    initial begin
        do_reset();
        #1;
        check("rst_grant", grant, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", order_count, 0);
        check("rst_state", state_dbg, 0);
        check("rst_data", {out_src, out_side, out_price}, 0);

        // single source
        price = {8'h44, 8'h37, 8'h22, 8'h11};
        side  = 4'b0100;
        push(2, 1'b1, 8'h37);
        req = 4'b0100;
        wait_grant(n);
        req = 4'b0000;
        bcnt = busy ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check("single_busy_cycles", bcnt, 3);
        check("single_count", order_count, 1);

        // fairness: 16 orders round robin
        do_reset();
        price = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        side  = 4'b1010;
        for (int k = 0; k < 16; k++) push(k % 4, (k % 2) == 1, 8'hA0 + 8'(k % 4));
        space_chk = 4;
        req = 4'b1111;
        wait_empty(0, 100);
        req = 4'b0000;
        space_chk = 0;
        repeat (4) @(negedge clk);

        // halt raised in the grant cycle
        do_reset();
        price = {8'h00, 8'h00, 8'h55, 8'h50};
        side  = 4'b0000;
        push(0, 1'b0, 8'h50);
        req = 4'b0001;
        wait_grant(n);
        halt = 1'b1;
        req  = 4'b0010;
        @(negedge clk);
        check("halt_gap_busy", busy, 1);
        repeat (10) @(negedge clk);
        check("halted_state", state_dbg, 3);
        check("halted_busy", busy, 0);
        push(1, 1'b0, 8'h55);
        halt = 1'b0;
        wait_grant(n);
        req = 4'b0000;
        check("halt_release_latency", n, 2);
        wait_empty(0, 10);

        // 256 orders: order_count wraps to 0
        do_reset();
        price = {8'h00, 8'h00, 8'h00, 8'h5A};
        side  = 4'b0000;
        for (int k = 0; k < 256; k++) push(0, 1'b0, 8'h5A);
        space_chk = 4;
        req = 4'b0001;
        wait_empty(0, 1100);
        req = 4'b0000;
        space_chk = 0;
        check("wrap_count", order_count, 0);
        repeat (4) @(negedge clk);

        // async reset during ISSUE
        do_reset();
        price = {8'h84, 8'h77, 8'h66, 8'h55};
        side  = 4'b0010;
        push(2, 1'b0, 8'h77);
        req = 4'b0100;
        wait_grant(n);
        req = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        check("async_grant", grant, 0);
        check("async_valid", out_valid, 0);
        check("async_busy", busy, 0);
        check("async_state", state_dbg, 0);
        req = 4'b1010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        push(1, 1'b1, 8'h66);
        wait_grant(n);
        req = 4'b0000;
        wait_empty(0, 10);

        // GAP = 0 instance, alternating sources every 2 cycles
        do_reset();
        price0 = {8'h00, 8'h00, 8'h61, 8'h60};
        side0  = 4'b0001;
        for (int k = 0; k < 8; k++)
            exp0_q.push_back(mk(k % 2, (k % 2) == 0, 8'h60 + 8'(k % 2), k + 1));
        space_chk0 = 2;
        req0 = 4'b0011;
        wait_empty(1, 50);
        req0 = 4'b0000;
        space_chk0 = 0;
        repeat (4) @(negedge clk);
        check("gap0_count", order_count0, 8);

        check("leftover_expected", exp_q.size() + exp0_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
